// File: rtl/divider_pkg.sv
// Shared types and helpers for the iterative restoring divider.
package divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Iteration counter width; never narrower than one bit.
  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/divider_iterative_if.sv
// Request/response handshake bundle for divider_iterative.
interface divider_iterative_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] R;
  logic             div_by_zero;

  modport master (
    output in_valid, A, B, out_ready,
    input  in_ready, out_valid, Q, R, div_by_zero
  );

  modport slave (
    input  in_valid, A, B, out_ready,
    output in_ready, out_valid, Q, R, div_by_zero
  );
endinterface

// File: rtl/divider_iterative_div_step.sv
// One combinational restoring-division iteration: shift in a dividend bit, trial-subtract.
module div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   rem,
  input  logic             msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_next,
  output logic             q_bit
);
  logic [WIDTH:0] shifted;
  logic           unused_rem_msb;

  // The restored remainder is always below the divisor, so its top bit is zero.
  assign unused_rem_msb = rem[WIDTH];
  assign shifted        = {rem[WIDTH-1:0], msb};
  assign q_bit          = (shifted >= {1'b0, divisor});
  assign rem_next       = q_bit ? (shifted - {1'b0, divisor}) : shifted;
endmodule

// File: rtl/divider_iterative.sv
// Unsigned iterative restoring divider, one quotient bit per clock.
// Define DIVIDER_DIV0_FASTPATH_EN to complete B == 0 requests in one cycle.
module divider_iterative
  import divider_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  divider_iterative_if.slave  bus
);
  localparam int CNT_W = cnt_width(WIDTH);

`ifdef DIVIDER_DIV0_FASTPATH_EN
  localparam bit FASTPATH = 1'b1;
`else
  localparam bit FASTPATH = 1'b0;
`endif

  state_t           state, state_next;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] dividend, divisor, quo;
  logic [WIDTH:0]   rem, rem_next;
  logic             q_bit, dbz;
  logic             in_ready, out_valid, accept, b_zero;

  assign b_zero = (bus.B == '0);
  assign accept = in_ready && bus.in_valid;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem),
    .msb      (dividend[WIDTH-1]),
    .divisor  (divisor),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) state_next = (FASTPATH && b_zero) ? DONE : BUSY;
      end
      BUSY: if (count == '0) state_next = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= '0;
      dividend <= '0;
      divisor  <= '0;
      quo      <= '0;
      rem      <= '0;
      dbz      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          dividend <= bus.A;
          divisor  <= bus.B;
          count    <= CNT_W'(WIDTH - 1);
          dbz      <= b_zero;
          // Divide-by-zero result is known up front: all-ones quotient, R = A.
          if (FASTPATH && b_zero) begin
            quo <= '1;
            rem <= {1'b0, bus.A};
          end else begin
            quo <= '0;
            rem <= '0;
          end
        end
        BUSY: begin
          rem      <= rem_next;
          quo      <= {quo[WIDTH-2:0], q_bit};
          dividend <= {dividend[WIDTH-2:0], 1'b0};
          if (count != '0) count <= count - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid;
  assign bus.Q           = quo;
  assign bus.R           = rem[WIDTH-1:0];
  assign bus.div_by_zero = dbz;
endmodule

// File: tb/tb_divider_iterative.sv
// Scoreboard bench for divider_iterative: driver pushes reference results, monitor pops and compares.
module tb_divider_iterative;
  localparam int W = 8;

`ifdef DIVIDER_DIV0_FASTPATH_EN
  localparam int DIV0_LAT = 1;
`else
  localparam int DIV0_LAT = W;
`endif

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    int           lat;
    int           acc_cyc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   acc_cnt;
  int   checks;
  int   errors;
  exp_t sb[$];

  divider_iterative_if #(.WIDTH(W)) bus ();

  divider_iterative #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst_n && bus.in_valid && bus.in_ready) acc_cnt = acc_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain arithmetic, RISC-V divide-by-zero rule.
  function automatic exp_t model(input int a, input int b);
    exp_t e;
    if (b == 0) begin
      e.q = '1; e.r = W'(a); e.dbz = 1'b1; e.lat = DIV0_LAT;
    end else begin
      e.q = W'(a / b); e.r = W'(a % b); e.dbz = 1'b0; e.lat = W;
    end
    e.acc_cyc = 0;
    return e;
  endfunction

  // Monitor: compare on every rising out_valid.
  initial begin
    logic prev_ov;
    exp_t e;
    prev_ov = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.out_valid && !prev_ov) begin
        if (sb.size() == 0) begin
          check("spurious_out_valid", 32'(bus.out_valid), 0);
        end else begin
          e = sb.pop_front();
          check("quotient", 32'(bus.Q), 32'(e.q));
          check("remainder", 32'(bus.R), 32'(e.r));
          check("div_by_zero", 32'(bus.div_by_zero), 32'(e.dbz));
          check("latency", 32'(cyc - e.acc_cyc), 32'(e.lat));
        end
      end
      prev_ov = bus.out_valid;
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!bus.in_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_wait", 32'(bus.in_ready), 1);
  endtask

  task automatic do_req(input int a, input int b);
    exp_t e;
    @(negedge clk);
    wait_ready();
    bus.in_valid = 1'b1;
    bus.A = W'(a);
    bus.B = W'(b);
    @(posedge clk);
    #1;
    e = model(a, b);
    e.acc_cyc = cyc;
    sb.push_back(e);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.A = W'($urandom);
    bus.B = W'($urandom);
  endtask

  task automatic wait_out_valid();
    int n = 0;
    while (!bus.out_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("out_valid_wait", 32'(bus.out_valid), 1);
  endtask

  initial begin
    int a0;
    exp_t e;
    cyc = 0; acc_cnt = 0; checks = 0; errors = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.A = '0; bus.B = '0; bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 1);
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_q", 32'(bus.Q), 0);
    check("rst_r", 32'(bus.R), 0);
    check("rst_dbz", 32'(bus.div_by_zero), 0);
    rst_n = 1'b1;

    // Directed cases with out_ready tied high.
    do_req(13, 4);   wait_out_valid();
    do_req(3, 7);    wait_out_valid();
    do_req(255, 1);  wait_out_valid();
    do_req(255, 255); wait_out_valid();
    do_req(200, 0);  wait_out_valid();
    do_req(0, 9);    wait_out_valid();

    // Backpressure: result held while out_ready is low.
    @(negedge clk);
    bus.out_ready = 1'b0;
    do_req(50, 6);
    wait_out_valid();
    e = model(50, 6);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_out_valid", 32'(bus.out_valid), 1);
      check("bp_in_ready", 32'(bus.in_ready), 0);
      check("bp_q", 32'(bus.Q), 32'(e.q));
      check("bp_r", 32'(bus.R), 32'(e.r));
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_out_valid", 32'(bus.out_valid), 0);
    check("bp_release_in_ready", 32'(bus.in_ready), 1);

    // Operands churn while busy with in_valid held high.
    @(negedge clk);
    wait_ready();
    a0 = acc_cnt;
    bus.in_valid = 1'b1; bus.A = 8'd77; bus.B = 8'd9;
    @(posedge clk);
    #1;
    e = model(77, 9);
    e.acc_cyc = cyc;
    sb.push_back(e);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.out_valid) break;
      bus.A = W'($urandom);
      bus.B = W'($urandom);
    end
    bus.in_valid = 1'b0;
    check("churn_out_valid", 32'(bus.out_valid), 1);
    @(negedge clk);
    wait_ready();
    check("churn_single_accept", 32'(acc_cnt - a0), 1);

    // Randomized operands, every sixth divisor forced to zero.
    for (int i = 0; i < 24; i++) begin
      do_req(int'($urandom_range(0, 255)), (i % 6 == 0) ? 0 : int'($urandom_range(1, 255)));
      wait_out_valid();
    end

    // Asynchronous reset mid-iteration aborts with no result.
    do_req(123, 5);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", 32'(bus.out_valid), 0);
    check("abort_q", 32'(bus.Q), 0);
    check("abort_r", 32'(bus.R), 0);
    check("abort_in_ready", 32'(bus.in_ready), 1);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    do_req(100, 7);
    wait_out_valid();
    check("post_reset_q", 32'(bus.Q), 14);
    check("post_reset_r", 32'(bus.R), 2);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
